// File: rtl/proc_run_monitor.sv
// Run monitor: holds a processor in reset, lets it run for a bounded number of cycles,
// and traces every change on its output into a first-word-fall-through FIFO.
module proc_run_monitor #(
    parameter int                DATA_W      = 32,
    parameter int                HOLD_CYCLES = 1,
    parameter int                MAX_CYCLES  = 100,
    parameter int                TRACE_DEPTH = 16,
    parameter bit                END_EN      = 1'b0,
    parameter logic [DATA_W-1:0] END_VALUE   = '0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [DATA_W-1:0]                io_out,
    output logic                             cpu_reset,
    output logic                             running,
    output logic                             done,
    output logic                             pass,
    output logic                             timeout,
    output logic [31:0]                      cycle_cnt,
    input  logic                             rd_en,
    output logic [32+DATA_W-1:0]             rd_data,
    output logic                             rd_empty,
    output logic [$clog2(TRACE_DEPTH):0]     trace_count,
    output logic                             overflow
);
    localparam int AW = $clog2(TRACE_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 32 + DATA_W;
    localparam logic [CW-1:0] FULL_CNT  = CW'(TRACE_DEPTH);
    localparam logic [31:0]   LAST_CYC  = 32'(MAX_CYCLES - 1);
    localparam logic [31:0]   LAST_HOLD = 32'(HOLD_CYCLES - 1);

    localparam logic [1:0] S_HOLD = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [31:0]       hold_cnt_q, hold_cnt_d;
    logic [31:0]       cycle_cnt_q, cycle_cnt_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              prev_vld_q, prev_vld_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic              overflow_q, overflow_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [EW-1:0]     mem_q [TRACE_DEPTH];

    logic in_run, capture, end_hit, budget_hit, pop, full, push;

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        prev_d      = prev_q;
        prev_vld_d  = prev_vld_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        overflow_d  = overflow_q;

        in_run     = (state_q == S_RUN);
        capture    = in_run && (!prev_vld_q || (io_out != prev_q));
        end_hit    = END_EN && in_run && (io_out == END_VALUE);
        budget_hit = in_run && (cycle_cnt_q == LAST_CYC);
        pop        = rd_en && (count_q != '0);
        full       = (count_q == FULL_CNT);
        // A pop in the same cycle frees the slot a full-FIFO push needs.
        push       = capture && (!full || pop);

        case (state_q)
            S_HOLD: begin
                if (hold_cnt_q == LAST_HOLD) begin
                    state_d = S_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 32'd1;
                end
            end
            S_RUN: begin
                prev_d     = io_out;
                prev_vld_d = 1'b1;
                // End-match outranks the budget when both land in the same cycle.
                if (end_hit) begin
                    state_d = S_DONE;
                    pass_d  = 1'b1;
                end else if (budget_hit) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else begin
                    cycle_cnt_d = cycle_cnt_q + 32'd1;
                end
            end
            S_DONE: ;
            default: state_d = S_HOLD;
        endcase

        if (capture && full && !pop) begin
            overflow_d = 1'b1;
        end

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);

        cpu_reset_d = (state_d != S_RUN);
        running_d   = (state_d == S_RUN);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_HOLD;
            hold_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            overflow_q  <= 1'b0;
            cpu_reset_q <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            overflow_q  <= overflow_d;
            cpu_reset_q <= cpu_reset_d;
            running_q   <= running_d;
            done_q      <= done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Trace storage carries no reset; only pointers and count define its contents.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= {cycle_cnt_q, io_out};
        end
    end

    assign cpu_reset   = cpu_reset_q;
    assign running     = running_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign overflow    = overflow_q;
    assign cycle_cnt   = cycle_cnt_q;
    assign rd_data     = mem_q[rd_ptr_q];
    assign rd_empty    = (count_q == '0);
    assign trace_count = count_q;
endmodule

// File: doc/proc_run_monitor.md
PROC_RUN_MONITOR -- requirements
Module: proc_run_monitor

Interface
REQ-001 Parameter DATA_W, default 32: width of the monitored processor output.
REQ-002 Parameter HOLD_CYCLES, default 1: cycles processor reset is held after monitor reset; legal range >=1.
REQ-003 Parameter MAX_CYCLES, default 100: run-cycle budget before timeout; legal range >=1.
REQ-004 Parameter TRACE_DEPTH, default 16: trace FIFO entries; power of 2, >=2.
REQ-005 Parameter END_EN, default 0: 1 enables early stop on END_VALUE.
REQ-006 Parameter END_VALUE, default 0: io_out value signalling program end.
REQ-007 clock  in  1  sole clock; all state updates on its rising edge.
REQ-008 reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
REQ-009 io_out  in  DATA_W  processor output under observation.
REQ-010 cpu_reset  out  1  reset driven to the processor.
REQ-011 running  out  1  high while in RUN.
REQ-012 done  out  1  high while in DONE.
REQ-013 pass  out  1  sticky: run ended by END_VALUE match.
REQ-014 timeout  out  1  sticky: run ended by exhausting MAX_CYCLES.
REQ-015 cycle_cnt  out  32  index of current RUN cycle; frozen in DONE.
REQ-016 rd_en  in  1  pop request for trace FIFO.
REQ-017 rd_data  out  32+DATA_W  oldest trace entry {cycle[31:0], value[DATA_W-1:0]}, first-word fall-through.
REQ-018 rd_empty  out  1  trace FIFO empty.
REQ-019 trace_count  out  log2(TRACE_DEPTH)+1  entries held.
REQ-020 overflow  out  1  sticky: a trace write was dropped.

Function
REQ-021 FSM states HOLD, RUN, DONE, all outputs registered.
REQ-022 HOLD: cpu_reset=1 for exactly HOLD_CYCLES cycles after the cycle reset is sampled low, then RUN; cpu_reset=0 in the first RUN cycle.
REQ-023 RUN: cycle_cnt=0 in the first RUN cycle, +1 each subsequent RUN cycle; 32-bit wrap permitted.
REQ-024 Capture: in the first RUN cycle, and in any RUN cycle where io_out differs from the io_out sampled in the previous RUN cycle, push {cycle_cnt, io_out}.
REQ-025 End-match: END_EN=1 and io_out==END_VALUE in a RUN cycle -> DONE next cycle, pass=1; that cycle's capture still occurs.
REQ-026 Budget: cycle_cnt==MAX_CYCLES-1 in a RUN cycle -> DONE next cycle, timeout=1.
REQ-027 End-match and budget in the same cycle: pass=1, timeout=0.
REQ-028 DONE: cpu_reset=1 (processor frozen), no captures, cycle_cnt held, DONE held until reset.
REQ-029 FIFO push when full and no pop the same cycle: entry dropped, overflow=1, contents unchanged.
REQ-030 Push and pop the same cycle when full: both occur, no overflow, trace_count unchanged.
REQ-031 rd_en while empty: ignored; a simultaneous push is accepted, trace_count becomes 1.
REQ-032 rd_data undefined-but-stable while rd_empty=1; pops are permitted in any state.

Reset
REQ-033 reset=1 at any time, including mid-RUN or DONE, overrides all other events: next state HOLD, hold counter 0, cpu_reset=1, running=0, done=0, pass=0, timeout=0, overflow=0, cycle_cnt=0, FIFO emptied (rd_empty=1, trace_count=0), previous-sample register cleared.

Verification
REQ-034 Defaults, io_out constant 5, reset high 1 cycle -> cpu_reset high 1 cycle after release; timeout=1 after 100 RUN cycles, cycle_cnt=99; trace holds exactly one entry {0,5}.
REQ-035 END_EN=1, END_VALUE=0xFFFFFFFF, io_out 1,2,0xFFFFFFFF on RUN cycles 0,3,7 -> pass=1, timeout=0, done one cycle after cycle 7; trace {0,1},{3,2},{7,0xFFFFFFFF}; cpu_reset=1 in DONE.
REQ-036 TRACE_DEPTH=4, io_out changing every cycle, no reads -> trace_count=4 at cycle 3, overflow=1 at the next push; popped entries are cycles 0..3 in order.
REQ-037 Full FIFO with simultaneous rd_en and change -> trace_count remains 4, overflow stays 0; rd_en on an empty FIFO with a change -> trace_count=1.
REQ-038 MAX_CYCLES=8, END_EN=1, END_VALUE matching at cycle_cnt 7 -> pass=1, timeout=0.
REQ-039 reset asserted at RUN cycle 20 with 3 entries queued and overflow=1 -> next cycle all flags 0, FIFO empty, cpu_reset=1, HOLD_CYCLES=3 hold repeats before RUN restarts at cycle_cnt=0.
